// File: rtl/axis_packet_arbiter.sv
`timescale 1ns/1ps
// Round-robin, packet-locked AXI-Stream merge of NUM_PORTS sources onto one registered master.
// Latency: request seen in IDLE -> grant next edge -> first beat on m_* two edges after request.
// Backpressure: s_tready[g] = ~m_tvalid | m_tready; all slave readies are low while the output stalls.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   s_tdata/s_tlast/s_tvalid     packed slave inputs, port i at [i*DWIDTH +: DWIDTH]
//   s_tready                     per-port ready, at most one bit high
//   m_tdata/m_tid/m_tlast/m_tvalid registered master outputs, m_tid = source port index
//   m_tready                     downstream ready
module axis_packet_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DWIDTH    = 8,
    parameter int ID_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DWIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]        s_tlast,
    input  logic [NUM_PORTS-1:0]        s_tvalid,
    output logic [NUM_PORTS-1:0]        s_tready,
    output logic [DWIDTH-1:0]           m_tdata,
    output logic [ID_WIDTH-1:0]         m_tid,
    output logic                        m_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready
);

    typedef enum logic {IDLE, PASS} state_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] grant_q;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [DWIDTH-1:0]   m_tdata_q;
    logic [ID_WIDTH-1:0] m_tid_q;
    logic                m_tlast_q;
    logic                m_tvalid_q;

    logic [ID_WIDTH-1:0] sel_d;
    logic [ID_WIDTH-1:0] ptr_d;
    logic                req_any_d;
    logic [DWIDTH-1:0]   g_data;
    logic                g_last;
    logic                g_valid;
    logic                out_free;
    logic                accept;

    // Round-robin search starting at ptr_q, wrapping past NUM_PORTS-1.
    always_comb begin
        int                  idx;
        logic [ID_WIDTH-1:0] idx_w;
        sel_d     = ptr_q;
        req_any_d = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_w = ID_WIDTH'(idx);
            if (!req_any_d && s_tvalid[idx_w]) begin
                req_any_d = 1'b1;
                sel_d     = idx_w;
            end
        end
    end

    assign ptr_d = (sel_d == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : sel_d + 1'b1;

    // Mux of the granted port's payload.
    always_comb begin
        g_data  = '0;
        g_last  = 1'b0;
        g_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                g_data  = s_tdata[i*DWIDTH +: DWIDTH];
                g_last  = s_tlast[i];
                g_valid = s_tvalid[i];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign out_free = ~m_tvalid_q | m_tready;
    assign accept   = (state_q == PASS) & g_valid & out_free;

    // Ready comes from registered state only, so reset forces it low immediately.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == PASS) && (grant_q == ID_WIDTH'(i))) begin
                s_tready[i] = out_free;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            m_tdata_q  <= '0;
            m_tid_q    <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Arbitration does not wait for the output register to drain.
                    if (req_any_d) begin
                        grant_q <= sel_d;
                        ptr_q   <= ptr_d;
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (accept && g_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                m_tdata_q  <= g_data;
                m_tlast_q  <= g_last;
                m_tid_q    <= grant_q;
                m_tvalid_q <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tid    = m_tid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
`timescale 1ns/1ps
// Directed bench for axis_packet_arbiter with a scoreboard of expected output beats.
// Sources are queue-driven per port; a negedge monitor pops and compares each handshake.
// Also checks one-hot ready, stall stability, arbitration latency, locking and reset.
module tb_axis_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic          last;
        logic [DW-1:0] dat;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]    s_tlast;
    logic [NP-1:0]    s_tvalid;
    logic [NP-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [IW-1:0]    m_tid;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready = 1'b0;

    logic [8:0] srcq [NP][$];
    beat_t      expq[$];
    int         checks   = 0;
    int         failures = 0;
    int         popped   = 0;
    logic [NP-1:0] acc;

    axis_packet_arbiter #(.NUM_PORTS(NP), .DWIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tid(m_tid), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic src(input int p, input logic [7:0] d, input logic l);
        srcq[p].push_back({l, d});
        expq.push_back({IW'(p), l, d});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()
                + expq.size() != 0 || m_tvalid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, 32'(n < 200), 1);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (popped < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pop_budget", 32'(n < 100), 1);
    endtask

    // Source driver: retire beats accepted at this edge, then present queue heads.
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(posedge clk);
            acc = s_tvalid & s_tready;
            #1;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
                if (srcq[p].size() > 0) begin
                    s_tvalid[p]            = 1'b1;
                    s_tdata[p*DW +: DW]    = srcq[p][0][7:0];
                    s_tlast[p]             = srcq[p][0][8];
                end else begin
                    s_tvalid[p]            = 1'b0;
                    s_tdata[p*DW +: DW]    = '0;
                    s_tlast[p]             = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pops on handshake, plus stall and ready rules.
    initial begin
        beat_t got;
        beat_t want;
        beat_t held;
        logic  stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 1'b0;
            end else begin
                chk("sready_onehot", 32'($countones(s_tready) <= 1), 1);
                got = {m_tid, m_tlast, m_tdata};
                if (stalled) begin
                    chk("stall_valid", 32'(m_tvalid), 1);
                    chk("stall_hold", 32'(got), 32'(held));
                end
                if (m_tvalid && !m_tready) chk("stall_sready", 32'(s_tready), 0);
                stalled = m_tvalid && !m_tready;
                held    = got;
                if (m_tvalid && m_tready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got 0x%0h, want none at %0t", got, $time);
                    end else begin
                        want = expq.pop_front();
                        chk("beat", 32'(got), 32'(want));
                    end
                    popped++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] vhist;

        // Reset state.
        #2;
        chk("rst_mvalid", 32'(m_tvalid), 0);
        chk("rst_mdata", 32'(m_tdata), 0);
        chk("rst_mtid", 32'(m_tid), 0);
        chk("rst_mlast", 32'(m_tlast), 0);
        chk("rst_sready", 32'(s_tready), 0);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        chk("post_rst_mvalid", 32'(m_tvalid), 0);
        chk("post_rst_sready", 32'(s_tready), 0);

        // Single-port packet on port 2, latency request+2, three back-to-back beats.
        src(2, 8'h11, 1'b0);
        src(2, 8'h22, 1'b0);
        src(2, 8'h33, 1'b1);
        @(negedge clk);
        chk("t1_lat_a", 32'(m_tvalid), 0);
        @(negedge clk);
        chk("t1_lat_b", 32'(m_tvalid), 0);
        chk("t1_grant_sready", 32'(s_tready), 32'h4);
        @(negedge clk);
        chk("t1_first_valid", 32'(m_tvalid), 1);
        chk("t1_tid", 32'(m_tid), 2);
        @(negedge clk);
        chk("t1_second_valid", 32'(m_tvalid), 1);
        @(negedge clk);
        chk("t1_third_valid", 32'(m_tvalid), 1);
        chk("t1_third_last", 32'(m_tlast), 1);
        wait_drain("t1");

        // Wrap-around: ptr=3, ports 3 and 0 request together -> 3 then 0, ptr ends at 1.
        src(3, 8'hA1, 1'b0);
        src(3, 8'hA2, 1'b1);
        src(0, 8'hB1, 1'b1);
        wait_drain("t2");

        // ptr=1: port 1 wins over port 0, and port 0 stays locked out for the whole packet.
        src(1, 8'hC1, 1'b0);
        src(1, 8'hC2, 1'b0);
        src(1, 8'hC3, 1'b0);
        src(1, 8'hC4, 1'b1);
        src(0, 8'hD1, 1'b0);
        src(0, 8'hD2, 1'b1);
        for (int n = 0; n < 40 && srcq[1].size() > 0; n++) begin
            @(negedge clk);
            chk("lock_sready0", 32'(s_tready[0]), 0);
        end
        wait_drain("t3");

        // Fresh reset; ports 0 and 1 simultaneously with a one-cycle gap between packets.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vhist = '0;
        src(0, 8'h01, 1'b0);
        src(0, 8'h02, 1'b1);
        src(1, 8'h03, 1'b0);
        src(1, 8'h04, 1'b1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            vhist = {vhist[6:0], m_tvalid};
        end
        chk("t4_valid_pattern", 32'(vhist), 32'h36);
        wait_drain("t4");

        // Backpressure: m_tready low for 5 cycles mid-packet on port 2.
        base = popped;
        src(2, 8'hE1, 1'b0);
        src(2, 8'hE2, 1'b0);
        src(2, 8'hE3, 1'b0);
        src(2, 8'hE4, 1'b1);
        wait_pops(base + 1);
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_held_valid", 32'(m_tvalid), 1);
        chk("t5_held_sready", 32'(s_tready), 0);
        m_tready = 1'b1;
        wait_drain("t5");

        // Reset mid-packet between edges, then a fresh request from port 3.
        base = popped;
        src(1, 8'hF1, 1'b0);
        src(1, 8'hF2, 1'b0);
        srcq[1].push_back({1'b0, 8'hF3});
        srcq[1].push_back({1'b1, 8'hF4});
        wait_pops(base + 2);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_mvalid", 32'(m_tvalid), 0);
        chk("t6_rst_sready", 32'(s_tready), 0);
        chk("t6_rst_mtid", 32'(m_tid), 0);
        for (int p = 0; p < NP; p++) srcq[p].delete();
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        src(3, 8'h5A, 1'b1);
        @(negedge clk);
        chk("t6_lat_a", 32'(m_tvalid), 0);
        @(negedge clk);
        chk("t6_lat_b", 32'(m_tvalid), 0);
        chk("t6_grant_sready", 32'(s_tready), 32'h8);
        @(negedge clk);
        chk("t6_first_valid", 32'(m_tvalid), 1);
        chk("t6_tid", 32'(m_tid), 3);
        wait_drain("t6");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
